// File: rtl/force_vector_sequencer_pkg.sv
// Shared definitions for the force vector sequencer: FSM state encoding and
// the buffer entry layout ({DRIVE, DATA}, DRIVE in the upper half).
package force_vector_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    function automatic int entry_width(input int pins);
        return 2 * pins;
    endfunction

endpackage

// File: rtl/force_vector_sequencer_fifo.sv
// vec_fifo: generic synchronous show-ahead FIFO with flush; the head entry is
// presented combinationally on o_rd_data whenever the FIFO is non-empty.
module vec_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    input  logic             i_flush
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr      = i_wr_en && !o_full && !i_flush;
    assign w_rd      = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/force_vector_sequencer.sv
// Force vector sequencer: buffers {DRIVE, DATA} vectors and applies one every
// PERIOD clocks to the pin tristate registers. Optional macro FORCE_HOLD_LAST_EN
// keeps the last vector driven on underrun instead of releasing the pins.
module force_vector_sequencer
    import force_vector_sequencer_pkg::*;
#(
    parameter int PINS  = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [PINS-1:0]  i_vec_data,
    input  logic [PINS-1:0]  i_vec_drive,
    input  logic             i_vec_valid,
    output logic             o_vec_ready,
    input  logic [CNT_W-1:0] i_period,
    input  logic             i_start,
    input  logic             i_stop,
    output logic [PINS-1:0]  o_force_i,
    output logic [PINS-1:0]  o_force_t,
    output logic             o_busy,
    output logic             o_underrun,
    output logic [CNT_W-1:0] o_vec_count
);
    localparam int ENTRY_W = entry_width(PINS);

    function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
        return (p == '0) ? CNT_W'(1) : p;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_period_use;
    logic [CNT_W-1:0]   w_count_base;
    logic [ENTRY_W-1:0] w_rd_data;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_start_run;
    logic               w_release;
    logic               w_set_underrun;
    logic               w_terminal;

    assign o_vec_ready  = !w_full;
    assign o_busy       = (r_state != ST_IDLE);
    assign w_terminal   = (r_cnt == CNT_W'(1));
    // The first pop happens in the START cycle, before r_period is loaded.
    assign w_period_use = (r_state == ST_IDLE) ? clamp_period(i_period) : r_period;
    assign w_count_base = w_start_run ? '0 : o_vec_count;

    vec_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (i_vec_valid),
        .i_wr_data ({i_vec_drive, i_vec_data}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .i_flush   (i_stop)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_start_run    = 1'b0;
        w_release      = 1'b0;
        w_set_underrun = 1'b0;
        if (i_stop) begin
            w_state_nxt = ST_IDLE;
            w_release   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        w_start_run = 1'b1;
                        if (!w_empty) begin
                            w_pop       = 1'b1;
                            w_state_nxt = ST_APPLY;
                        end else begin
                            w_state_nxt = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (w_terminal) begin
                        if (!w_empty) begin
                            w_pop = 1'b1;
                        end else begin
                            w_set_underrun = 1'b1;
`ifdef FORCE_HOLD_LAST_EN
                            w_state_nxt    = ST_APPLY;
`else
                            w_release      = 1'b1;
                            w_state_nxt    = ST_IDLE;
`endif
                        end
                    end
                end
                default: begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_period    <= CNT_W'(1);
            r_cnt       <= '0;
            o_force_i   <= '0;
            o_force_t   <= '1;
            o_underrun  <= 1'b0;
            o_vec_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_run) begin
                r_period    <= clamp_period(i_period);
                o_underrun  <= 1'b0;
                o_vec_count <= '0;
            end
            if (w_set_underrun) begin
                o_underrun <= 1'b1;
            end
            // Down-counter sits at 1 (terminal) while holding past an underrun.
            if (w_pop) begin
                o_force_i   <= w_rd_data[PINS-1:0];
                o_force_t   <= ~w_rd_data[ENTRY_W-1:PINS];
                r_cnt       <= w_period_use;
                o_vec_count <= w_count_base + CNT_W'(1);
            end else if (w_release) begin
                o_force_i <= '0;
                o_force_t <= '1;
                r_cnt     <= '0;
            end else if (r_state == ST_APPLY && !w_terminal) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_force_vector_sequencer.sv
// Self-checking bench for force_vector_sequencer: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a queue model.
module tb_force_vector_sequencer;
    localparam int PINS  = 8;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [PINS-1:0]  vec_data = '0;
    logic [PINS-1:0]  vec_drive = '0;
    logic             vec_valid = 1'b0;
    logic             vec_ready;
    logic [CNT_W-1:0] period = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [PINS-1:0]  force_i;
    logic [PINS-1:0]  force_t;
    logic             busy;
    logic             underrun;
    logic [CNT_W-1:0] vec_count;

    int n_chk  = 0;
    int n_pass = 0;

    force_vector_sequencer #(.PINS(PINS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_vec_data  (vec_data),
        .i_vec_drive (vec_drive),
        .i_vec_valid (vec_valid),
        .o_vec_ready (vec_ready),
        .i_period    (period),
        .i_start     (start),
        .i_stop      (stop),
        .o_force_i   (force_i),
        .o_force_t   (force_t),
        .o_busy      (busy),
        .o_underrun  (underrun),
        .o_vec_count (vec_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: pending vectors in a queue, the running vector's remaining
    // hold cycles, and the expected pin outputs.
    logic [2*PINS-1:0] m_q[$];
    int                m_phase;   // 0 idle, 1 waiting for data, 2 applying
    int                m_left;
    int                m_per;
    logic [PINS-1:0]   m_fi;
    logic [PINS-1:0]   m_ft;
    bit                m_rel;
    bit                m_und;
    logic [CNT_W-1:0]  m_cnt;
    bit                m_on = 0;
    bit                m_acc;
    bit                m_pop;
    logic [2*PINS-1:0] m_e;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_phase = 0; m_left = 0; m_per = 1;
            m_fi = '0; m_ft = '1; m_rel = 1; m_und = 0; m_cnt = '0; m_on = 1;
        end else begin
            m_acc = vec_valid && (m_q.size() < DEPTH) && !stop;
            m_pop = 0;
            if (stop) begin
                m_q.delete();
                m_phase = 0; m_ft = '1; m_fi = '0; m_rel = 1;
            end else if (m_phase == 0) begin
                if (start) begin
                    m_per = (period == 0) ? 1 : int'(period);
                    m_cnt = '0; m_und = 0;
                    if (m_q.size() > 0) m_pop = 1;
                    else m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (m_q.size() > 0) m_pop = 1;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    if (m_q.size() > 0) m_pop = 1;
                    else begin
                        m_und = 1; m_phase = 0; m_ft = '1; m_fi = '0; m_rel = 1;
                    end
                end
            end
            if (m_pop) begin
                m_e = m_q.pop_front();
                m_fi = m_e[PINS-1:0];
                m_ft = ~m_e[2*PINS-1:PINS];
                m_rel = 0;
                m_cnt = m_cnt + 1'b1;
                m_left = m_per;
                m_phase = 2;
            end
            if (m_acc) m_q.push_back({vec_drive, vec_data});
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("force_t", 32'(force_t), 32'(m_ft));
            if (!m_rel) chk("force_i", 32'(force_i), 32'(m_fi));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("underrun", 32'(underrun), 32'(m_und));
            chk("vec_count", 32'(vec_count), 32'(m_cnt));
            chk("vec_ready", 32'(vec_ready), 32'(m_q.size() < DEPTH));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
    endtask

    task automatic write_vec(input logic [PINS-1:0] drv, input logic [PINS-1:0] dat);
        vec_drive = drv; vec_data = dat; vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [CNT_W-1:0] p);
        period = p; start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_force_t", 32'(force_t), 32'hFF);
        chk("rst_force_i", 32'(force_i), 32'h00);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_count", 32'(vec_count), 0);
        chk("rst_ready", 32'(vec_ready), 1);

        // Basic run, PERIOD=3
        write_vec(8'hFF, 8'hA5);
        write_vec(8'h0F, 8'h3C);
        pulse_start(16'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_v0_t", 32'(force_t), 32'h00);
            chk("t1_v0_i", 32'(force_i), 32'hA5);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk("t1_v1_t", 32'(force_t), 32'hF0);
            chk("t1_v1_i", 32'(force_i), 32'h3C);
            tick();
        end
        chk("t1_end_t", 32'(force_t), 32'hFF);
        chk("t1_end_und", 32'(underrun), 1);
        chk("t1_end_busy", 32'(busy), 0);
        chk("t1_end_cnt", 32'(vec_count), 2);

        // PERIOD=0 holds each vector one cycle
        write_vec(8'hFF, 8'hA5);
        write_vec(8'h0F, 8'h3C);
        pulse_start(16'd0);
        chk("t2_v0_i", 32'(force_i), 32'hA5);
        chk("t2_und_cleared", 32'(underrun), 0);
        tick();
        chk("t2_v1_i", 32'(force_i), 32'h3C);
        chk("t2_v1_t", 32'(force_t), 32'hF0);
        tick();
        chk("t2_end_t", 32'(force_t), 32'hFF);
        chk("t2_end_cnt", 32'(vec_count), 2);

        // WAIT state: start on empty buffer, write 5 cycles later
        pulse_start(16'd2);
        for (int i = 0; i < 5; i++) begin
            chk("t3_wait_busy", 32'(busy), 1);
            chk("t3_wait_t", 32'(force_t), 32'hFF);
            tick();
        end
        write_vec(8'hC3, 8'h5A);
        chk("t3_m1_t", 32'(force_t), 32'hFF);
        tick();
        chk("t3_m2_t", 32'(force_t), 32'h3C);
        chk("t3_m2_i", 32'(force_i), 32'h5A);
        repeat (4) tick();

        // Back-pressure
        do_reset();
        for (int i = 0; i < DEPTH; i++) write_vec(~8'(i * 17), 8'(i * 17));
        chk("t4_full_ready", 32'(vec_ready), 0);
        write_vec(8'hFF, 8'h77);
        chk("t4_17th_ready", 32'(vec_ready), 0);
        pulse_start(16'd1);
        chk("t4_after_pop_ready", 32'(vec_ready), 1);
        chk("t4_first_i", 32'(force_i), 32'h00);
        repeat (DEPTH + 3) tick();
        chk("t4_count", 32'(vec_count), DEPTH);

        // STOP mid-vector
        do_reset();
        write_vec(8'hFF, 8'h11);
        write_vec(8'hFF, 8'h22);
        write_vec(8'hFF, 8'h33);
        pulse_start(16'd10);
        repeat (3) tick();
        chk("t5_pre_stop_i", 32'(force_i), 32'h11);
        pulse_stop();
        chk("t5_stop_t", 32'(force_t), 32'hFF);
        chk("t5_stop_busy", 32'(busy), 0);
        chk("t5_stop_ready", 32'(vec_ready), 1);
        pulse_start(16'd10);
        chk("t5_wait_busy", 32'(busy), 1);
        chk("t5_wait_t", 32'(force_t), 32'hFF);
        pulse_stop();

        // Reset mid-APPLY, then START+STOP together
        write_vec(8'h0F, 8'h99);
        write_vec(8'hF0, 8'h66);
        pulse_start(16'd5);
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_rst_t", 32'(force_t), 32'hFF);
        chk("t6_rst_i", 32'(force_i), 32'h00);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_cnt", 32'(vec_count), 0);
        write_vec(8'hFF, 8'h44);
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chk("t6_ss_busy", 32'(busy), 0);
        chk("t6_ss_t", 32'(force_t), 32'hFF);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 999) < 3);
            stop      = ($urandom_range(0, 99) < 2);
            start     = ($urandom_range(0, 99) < 6);
            vec_valid = !stop && ($urandom_range(0, 1) == 1);
            vec_data  = 8'($urandom);
            vec_drive = 8'($urandom);
            period    = 16'($urandom_range(0, 4));
            tick();
        end
        rst = 1'b0; stop = 1'b0; start = 1'b0; vec_valid = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/force_vector_sequencer.md
Name: force_vector_sequencer

Overview:
- Upstream driver for the per-pin forcing tristate output registers of the ASIC tester.
- Buffers test vectors, each a pin-data word plus a per-pin drive mask, and applies one vector every PERIOD clocks.
- Produces the registered data/tristate pair that each pin's tristate register consumes.
- Releases all pins (high-Z) whenever not actively forcing, so DUT outputs are never fought.

Parameters:
- PINS, 8, number of forced pins.
- DEPTH, 16, vector buffer depth in entries; power of two, ≥2.
- CNT_W, 16, width of the period counter and the applied-vector counter.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous, active-high reset.
- VEC_DATA  input  PINS  pin levels for the vector being written.
- VEC_DRIVE  input  PINS  per-pin drive mask; 1 = drive the pin, 0 = release it.
- VEC_VALID  input  1  write request.
- VEC_READY  output  1  buffer can accept; a write occurs when VALID & READY.
- PERIOD  input  CNT_W  clocks each vector is held; sampled at START.
- START  input  1  single-cycle pulse that begins applying vectors.
- STOP  input  1  single-cycle pulse that aborts and flushes.
- FORCE_I  output  PINS  data to the pin tristate registers.
- FORCE_T  output  PINS  tristate control; 1 = high-Z, 0 = drive.
- BUSY  output  1  high in any state other than IDLE.
- UNDERRUN  output  1  sticky flag: buffer was empty at a vector boundary.
- VEC_COUNT  output  CNT_W  number of vectors applied since START; wraps modulo 2^CNT_W.

Behaviour:
- Only one clock and one reset exist: a single CLK, and RST is synchronous and active-high.
- Reset values:
  - FORCE_T = all 1s; FORCE_I = 0.
  - BUSY = 0; UNDERRUN = 0; VEC_COUNT = 0.
  - Buffer empty; VEC_READY = 1 on the first cycle after reset.
  - An RST mid-run releases all pins on the next edge and discards all buffered vectors.
- Buffer:
  - Synchronous FIFO, DEPTH entries, each entry {DRIVE, DATA}.
  - VEC_READY = !full. There is no write-to-read bypass.
  - A write in cycle m is visible as non-empty in cycle m+1.
  - A write and a pop in the same cycle are both legal; occupancy is unchanged.
- FSM states: IDLE, WAIT, APPLY.
- IDLE:
  - FORCE_T = all 1s.
  - On START, capture the period as max(PERIOD,1) into a period register, clear VEC_COUNT and clear UNDERRUN.
  - If the buffer is non-empty, pop and go to APPLY. Otherwise go to WAIT.
- WAIT:
  - Pins stay released.
  - On the first cycle the buffer is non-empty, pop and go to APPLY.
- APPLY:
  - Output latency: a pop in cycle n makes FORCE_I = DATA and FORCE_T = ~DRIVE from cycle n+1.
  - Increment VEC_COUNT in the same cycle the outputs update.
  - A down-counter is loaded with the captured period at each pop.
  - Each vector is held for exactly that many cycles.
  - At the terminal count with the buffer non-empty: pop the next vector back-to-back, with no gap cycle.
  - At the terminal count with the buffer empty: set UNDERRUN, release all pins the next cycle, and go to IDLE.
- STOP, from any state:
  - Flush the buffer, release all pins the next cycle, and go to IDLE.
  - UNDERRUN is held unchanged.
- START while BUSY is ignored.
- START and STOP in the same cycle: STOP wins.
- PERIOD changes are ignored after START.

Optional Feature:
- Macro: FORCE_HOLD_LAST_EN.
- Defined:
  - An underrun at a vector boundary still sets UNDERRUN.
  - The FSM stays in APPLY and holds the last vector's FORCE_I/FORCE_T.
  - The next buffered vector is popped as soon as the buffer becomes non-empty, and its period count restarts.
  - Only STOP or RST releases the pins.
- Undefined: underrun releases the pins and returns to IDLE, as above.

Decomposition:
- Shared package/header holds:
  - FSM state encoding constants (IDLE = 2'd0, WAIT = 2'd1, APPLY = 2'd2).
  - The entry-layout constant ENTRY_W = 2*PINS, with DRIVE in the upper half and DATA in the lower half.
- Sub-module vec_fifo: a generic synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: CLK, RST, WR_EN, WR_DATA, RD_EN, RD_DATA, FULL, EMPTY, FLUSH.
  - The sequencer instantiates it once.

Test Plan:
1. Basic run with PERIOD=3:
   - Stimulus: write vectors {DRIVE=FF, DATA=A5} and {DRIVE=0F, DATA=3C}, then START.
   - Response: FORCE_T=00/FORCE_I=A5 for 3 cycles starting the cycle after START.
   - Then FORCE_T=F0/FORCE_I=3C for 3 cycles.
   - Then FORCE_T=FF, UNDERRUN=1, BUSY=0, VEC_COUNT=2.
2. PERIOD=0:
   - Stimulus: same two vectors, START.
   - Response: each vector is held exactly 1 cycle, with back-to-back pops.
3. WAIT state:
   - Stimulus: START with an empty buffer, then a write 5 cycles later.
   - Response: BUSY=1 and FORCE_T=FF throughout the wait; the vector appears 2 cycles after its write.
4. Back-pressure:
   - Stimulus: write 16 vectors without START.
   - Response: VEC_READY=0.
   - A 17th VALID is not accepted; after START plus one pop, VEC_READY=1.
5. STOP mid-vector:
   - Stimulus: PERIOD=10, STOP on cycle 4 of vector 1.
   - Response: FORCE_T=FF next cycle, buffer empty, BUSY=0.
   - A following START enters WAIT.
6. Reset and simultaneous START+STOP:
   - RST mid-APPLY: all outputs at reset values on the next edge.
   - START+STOP in the same cycle from IDLE: stays in IDLE, BUSY=0.
